// File: rtl/spi_shift_engine.sv
// spi_shift_engine
//   Byte-wide SPI master shift engine. Accepts a start strobe with a data
//   byte, a half-period divisor and mode bits, generates SCLK, shifts MOSI
//   out MSB-first and samples MISO into the receive register.
//
// Ports
//   clk           : system clock
//   reset_n       : asynchronous active-low reset
//   din[7:0]      : byte to transmit, taken on an accepted start
//   dvsr[15:0]    : SCLK half-period minus one, in clk cycles
//   start         : single-cycle request, honoured only while ready=1
//   cpol          : SCLK idle level (followed live while idle)
//   cpha          : clock phase
//   miso          : serial data from slave
//   dout[7:0]     : last received byte
//   sclk          : registered serial clock
//   mosi          : serial data to slave (tx register bit 7)
//   spi_done_tick : one-cycle pulse in the last cycle of a transfer
//   ready         : idle and able to accept start
module spi_shift_engine (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  din,
    input  logic [15:0] dvsr,
    input  logic        start,
    input  logic        cpol,
    input  logic        cpha,
    input  logic        miso,
    output logic [7:0]  dout,
    output logic        sclk,
    output logic        mosi,
    output logic        spi_done_tick,
    output logic        ready
);

    typedef enum logic [1:0] {
        IDLE,
        CPHA_DLY,
        P0,
        P1
    } state_t;

    state_t      state;
    logic [15:0] c;
    logic [15:0] dvsr_q;
    logic [2:0]  n;
    logic [7:0]  tx;
    logic [7:0]  rx;
    logic        cpol_q;
    logic        cpha_q;
    logic        sclk_q;
    logic        half_done;

    assign half_done = (c == dvsr_q);

    // Every branch loads sclk_q with the level belonging to the state being
    // entered, so SCLK changes on the same edge as the state register:
    // level = cpol ^ pclk, pclk = (P0 & cpha) | (P1 & ~cpha).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            c      <= '0;
            dvsr_q <= '0;
            n      <= '0;
            tx     <= '0;
            rx     <= '0;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            sclk_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Both successors of IDLE have pclk=0, so the idle level
                    // is the live cpol whether or not a start is taken.
                    sclk_q <= cpol;
                    if (start) begin
                        tx     <= din;
                        dvsr_q <= dvsr;
                        cpol_q <= cpol;
                        cpha_q <= cpha;
                        c      <= '0;
                        n      <= '0;
                        state  <= cpha ? CPHA_DLY : P0;
                    end
                end
                CPHA_DLY: begin
                    if (half_done) begin
                        c      <= '0;
                        state  <= P0;
                        sclk_q <= ~cpol_q;
                    end else begin
                        c      <= c + 16'd1;
                        sclk_q <= cpol_q;
                    end
                end
                P0: begin
                    if (half_done) begin
                        rx     <= {rx[6:0], miso};
                        c      <= '0;
                        state  <= P1;
                        sclk_q <= cpol_q ^ ~cpha_q;
                    end else begin
                        c      <= c + 16'd1;
                        sclk_q <= cpol_q ^ cpha_q;
                    end
                end
                P1: begin
                    if (half_done) begin
                        c <= '0;
                        if (n == 3'd7) begin
                            state  <= IDLE;
                            sclk_q <= cpol;
                        end else begin
                            tx     <= {tx[6:0], 1'b0};
                            n      <= n + 3'd1;
                            state  <= P0;
                            sclk_q <= cpol_q ^ cpha_q;
                        end
                    end else begin
                        c      <= c + 16'd1;
                        sclk_q <= cpol_q ^ ~cpha_q;
                    end
                end
                default: begin
                    state  <= IDLE;
                    sclk_q <= cpol;
                end
            endcase
        end
    end

    assign sclk          = sclk_q;
    assign mosi          = tx[7];
    assign dout          = rx;
    assign ready         = (state == IDLE);
    assign spi_done_tick = (state == P1) && half_done && (n == 3'd7);

endmodule
